serial_subtractor_4bit: RTL and testbench

//  - Bit-serial, multi-cycle subtractor; inverse operation of the combinational 4-bit ripple adder.
//  - Computes diff = a - b - b_in, LSB first, one bit per clock, with valid/ready handshakes on both sides.
//  - Sits beside the adder in Custom_IP. Gives an area-cheap, sequential subtract path for datapaths that tolerate latency.

---
 rtl/serial_subtractor_4bit.sv | 145 ++++++++++++++
 tb/tb_serial_subtractor_4bit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_4bit.sv
// -----------------------------------------------------------------------------
// serial_subtractor_4bit
//   Bit-serial subtractor: diff = (a - b - b_in) mod 2^WIDTH, processed LSB
//   first, one bit per clock, with valid/ready handshakes on both sides.
//   Companion to the combinational ripple adder; trades latency for area.
//
//   Optional feature macro: SUB_OVERFLOW_EN adds the signed-overflow output
//   ovf. Without it, the port and its logic are absent.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      block idle, can accept operands
//   a          in   WIDTH  minuend (unsigned)
//   b          in   WIDTH  subtrahend (unsigned)
//   b_in       in   1      borrow in
//   out_valid  out  1      result valid, held until out_ready
//   out_ready  in   1      consumer accepts result
//   diff       out  WIDTH  (a - b - b_in) mod 2^WIDTH
//   b_out      out  1      borrow out, 1 iff a < b + b_in
//   ovf        out  1      signed overflow (SUB_OVERFLOW_EN only)
// -----------------------------------------------------------------------------
module serial_subtractor_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic             borrow_r;
    logic [CW-1:0]    cnt_r;
`ifdef SUB_OVERFLOW_EN
    logic             a_msb_r;
    logic             b_msb_r;
`endif

    logic             d_bit_s;
    logic             br_next_s;

    // One full-subtractor cell operating on the current LSBs of the shift regs
    assign d_bit_s   = a_sr_r[0] ^ b_sr_r[0] ^ borrow_r;
    assign br_next_s = (~a_sr_r[0] & b_sr_r[0]) | (~(a_sr_r[0] ^ b_sr_r[0]) & borrow_r);

    // Control FSM, datapath shift registers and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= {WIDTH{1'b0}};
            b_out     <= 1'b0;
            a_sr_r    <= {WIDTH{1'b0}};
            b_sr_r    <= {WIDTH{1'b0}};
            borrow_r  <= 1'b0;
            cnt_r     <= {CW{1'b0}};
`ifdef SUB_OVERFLOW_EN
            ovf       <= 1'b0;
            a_msb_r   <= 1'b0;
            b_msb_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sr_r   <= a;
                        b_sr_r   <= b;
                        borrow_r <= b_in;
                        cnt_r    <= {CW{1'b0}};
`ifdef SUB_OVERFLOW_EN
                        a_msb_r  <= a[WIDTH-1];
                        b_msb_r  <= b[WIDTH-1];
`endif
                        in_ready <= 1'b0;
                        state_r  <= S_SHIFT;
                    end else begin
                        state_r  <= S_IDLE;
                    end
                end

                S_SHIFT: begin
                    // WIDTH bit cycles, then one commit cycle that publishes
                    // the final borrow (and overflow) alongside out_valid.
                    if (cnt_r == CW'(WIDTH)) begin
                        b_out     <= borrow_r;
`ifdef SUB_OVERFLOW_EN
                        ovf       <= (a_msb_r ^ b_msb_r) & (diff[WIDTH-1] ^ a_msb_r);
`endif
                        out_valid <= 1'b1;
                        state_r   <= S_DONE;
                    end else begin
                        // Result bits enter from the MSB side so that after
                        // WIDTH shifts bit 0 sits at diff[0].
                        diff     <= {d_bit_s, diff[WIDTH-1:1]};
                        a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
                        b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
                        borrow_r <= br_next_s;
                        cnt_r    <= cnt_r + CW'(1);
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= S_IDLE;
                    end else begin
                        state_r   <= S_DONE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
module tb_serial_subtractor_4bit;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             b_out;
`ifdef SUB_OVERFLOW_EN
    logic             ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor_4bit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .b_out     (b_out)
`ifdef SUB_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full transaction: accept, WIDTH+1 cycles of latency, check, consume.
    task automatic run_op(input string tag, input logic [3:0] av, input logic [3:0] bv,
                          input logic bi, input logic [3:0] exp_d, input logic exp_bo,
                          input logic exp_ov);
        a = av; b = bv; b_in = bi; in_valid = 1'b1;
        chk({tag, "_in_ready"}, 8'(in_ready), 8'd1);
        step();                           // accept edge N
        in_valid = 1'b0;
        a = ~av; b = ~bv; b_in = ~bi;     // must not affect the result
        chk({tag, "_busy"}, 8'(in_ready), 8'd0);
        for (int i = 1; i <= WIDTH; i++) begin
            step();
            chk({tag, "_early_valid"}, 8'(out_valid), 8'd0);
        end
        step();                           // edge N+WIDTH+1
        chk({tag, "_valid"}, 8'(out_valid), 8'd1);
        chk({tag, "_diff"},  8'(diff),      8'(exp_d));
        chk({tag, "_bout"},  8'(b_out),     8'(exp_bo));
`ifdef SUB_OVERFLOW_EN
        chk({tag, "_ovf"},   8'(ovf),       8'(exp_ov));
`else
        if (exp_ov === 1'bx) chk({tag, "_ovf_x"}, 8'(exp_ov), 8'd0);
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_released"}, 8'(out_valid), 8'd0);
        chk({tag, "_idle"},     8'(in_ready),  8'd1);
        chk({tag, "_hold"},     8'(diff),      8'(exp_d));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 4'd0; b = 4'd0; b_in = 1'b0;

        // Reset held for two clocks
        step();
        step();
        chk("rst_in_ready",  8'(in_ready),  8'd1);
        chk("rst_out_valid", 8'(out_valid), 8'd0);
        chk("rst_diff",      8'(diff),      8'd0);
        chk("rst_bout",      8'(b_out),     8'd0);
`ifdef SUB_OVERFLOW_EN
        chk("rst_ovf",       8'(ovf),       8'd0);
`endif
        rst_n = 1'b1;
        step();

        // Directed vectors (hand computed)
        run_op("op_3_4_1",  4'd3,  4'd4,  1'b1, 4'hE, 1'b1, 1'b0);
        run_op("op_9_6_1",  4'd9,  4'd6,  1'b1, 4'h2, 1'b0, 1'b1);
        run_op("op_0_0_1",  4'd0,  4'd0,  1'b1, 4'hF, 1'b1, 1'b0);
        run_op("op_eq",     4'd5,  4'd5,  1'b0, 4'h0, 1'b0, 1'b0);
        run_op("op_wrap",   4'd0,  4'd15, 1'b1, 4'h0, 1'b1, 1'b0);
        run_op("op_15_0_0", 4'd15, 4'd0,  1'b0, 4'hF, 1'b0, 1'b0);
        run_op("op_8_1_0",  4'd8,  4'd1,  1'b0, 4'h7, 1'b0, 1'b1);
        run_op("op_7_15_0", 4'd7,  4'd15, 1'b0, 4'h8, 1'b1, 1'b1);
        run_op("op_5_3_0",  4'd5,  4'd3,  1'b0, 4'h2, 1'b0, 1'b0);

        // Backpressure: result held, in_valid ignored while in DONE
        a = 4'd9; b = 4'd6; b_in = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i <= WIDTH; i++) step();
        chk("bp_valid", 8'(out_valid), 8'd1);
        chk("bp_diff",  8'(diff),      8'h2);
        for (int i = 0; i < 3; i++) begin
            a = 4'd1; b = 4'd2; b_in = 1'b0; in_valid = 1'b1;
            step();
            chk("bp_hold_valid", 8'(out_valid), 8'd1);
            chk("bp_hold_diff",  8'(diff),      8'h2);
            chk("bp_hold_bout",  8'(b_out),     8'd0);
            chk("bp_no_ready",   8'(in_ready),  8'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_released", 8'(out_valid), 8'd0);
        chk("bp_idle",     8'(in_ready),  8'd1);

        // Reset in the middle of SHIFT aborts the operation
        a = 4'd3; b = 4'd4; b_in = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("mid_rst_ready", 8'(in_ready),  8'd1);
        chk("mid_rst_valid", 8'(out_valid), 8'd0);
        chk("mid_rst_diff",  8'(diff),      8'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            step();
            chk("mid_rst_no_stale", 8'(out_valid), 8'd0);
        end
        chk("mid_rst_idle", 8'(in_ready), 8'd1);

        // Operation after the aborted one completes normally
        run_op("post_rst", 4'd12, 4'd5, 1'b1, 4'h6, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
